countdown_loop: RTL and testbench

Programmable down-counter that runs the opposite direction of the team's 0→MX wrap counter. It counts from MX down to 0, then either wraps back to MX (loop mode) or stops (one-shot mode), and flags each arrival at 0 with a one-cycle terminal-count pulse. It serves as the tick/timeout source paired with the up-counter in the lab timing datapath.

---
 rtl/countdown_pkg.sv | 21 ++
 rtl/countdown_ctrl.sv | 66 ++++++
 rtl/countdown_loop.sv | 71 +++++++
 tb/tb_countdown_loop.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and default sizing for the lab timing counters.
// Holds the run-state enum and the count-select code used by countdown_loop.
package countdown_pkg;

  localparam int unsigned CD_WIDTH = 6;
  localparam int unsigned CD_MX    = 30;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_ZERO = 3'd1,
    SEL_MX   = 3'd2,
    SEL_DEC  = 3'd3,
    SEL_LOAD = 3'd4
  } sel_e;

endpackage

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/idle state, per-edge priority decode, tc and busy.
// Tells the datapath which next-count source to take each edge.
module countdown_ctrl
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic stop,
  input  logic loop,
  input  logic load,
  input  logic cnt_zero_i,
  input  logic cnt_one_i,
  output sel_e sel_o,
  output logic tc,
  output logic busy
);

  state_e state_q, state_d;
  logic   tc_q, tc_d;

  // Priority: rst > load > stop > start > count.
  always_comb begin
    state_d = state_q;
    sel_o   = SEL_HOLD;
    tc_d    = 1'b0;
    if (rst) begin
      state_d = IDLE;
      sel_o   = SEL_ZERO;
    end else if (load) begin
      sel_o   = SEL_LOAD;
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      sel_o   = SEL_MX;
    end else if (state_q == RUN && en) begin
      if (cnt_one_i) begin
        sel_o = SEL_DEC;
        tc_d  = 1'b1;
        if (!loop) state_d = IDLE;
      end else if (cnt_zero_i) begin
        if (loop) sel_o = SEL_MX;
        else      state_d = IDLE;
      end else begin
        sel_o = SEL_DEC;
      end
    end
  end

  // State and terminal-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: rtl/countdown_loop.sv
// countdown_loop: MX-to-0 down-counter with loop/one-shot and tc pulse.
// Define COUNTDOWN_LOOP_CLAMP_EN to clamp load_val values above MX to MX.
module countdown_loop
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH,
  parameter int unsigned MX    = CD_MX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MX_V  = WIDTH'(MX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_v;
  sel_e             sel;

  countdown_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .load       (load),
    .cnt_zero_i (count_q == '0),
    .cnt_one_i  (count_q == ONE_V),
    .sel_o      (sel),
    .tc         (tc),
    .busy       (busy)
  );

  // Load value, optionally limited to the reload value.
`ifdef COUNTDOWN_LOOP_CLAMP_EN
  assign load_v = (load_val > MX_V) ? MX_V : load_val;
`else
  assign load_v = load_val;
`endif

  // Next-count mux driven by the controller's select.
  always_comb begin
    count_d = count_q;
    unique case (sel)
      SEL_ZERO: count_d = '0;
      SEL_MX:   count_d = MX_V;
      SEL_DEC:  count_d = count_q - ONE_V;
      SEL_LOAD: count_d = load_v;
      default:  count_d = count_q;
    endcase
  end

  // Count register; reset clears it via SEL_ZERO as well.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_countdown_loop.sv
// tb_countdown_loop: directed scoreboard bench for countdown_loop.
// Expected count/tc/busy are queued per edge and checked 1ns after it.
module tb_countdown_loop;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, loop, load;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       tc, busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [5:0] c;
    logic       t;
    logic       b;
    string      tag;
  } exp_t;

  exp_t sb[$];

`ifdef COUNTDOWN_LOOP_CLAMP_EN
  localparam logic [5:0] CL = 6'd30;
`else
  localparam logic [5:0] CL = 6'd50;
`endif

  countdown_loop dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [5:0] c, input logic t,
                      input logic b, input string tag);
    exp_t e;
    sb.push_back('{c: c, t: t, b: b, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (count === e.c) else begin
      fails++;
      $error("FAIL %s count got %0d want %0d", e.tag, count, e.c);
    end
    checks++;
    assert (tc === e.t) else begin
      fails++;
      $error("FAIL %s tc got %b want %b", e.tag, tc, e.t);
    end
    checks++;
    assert (busy === e.b) else begin
      fails++;
      $error("FAIL %s busy got %b want %b", e.tag, busy, e.b);
    end
  endtask

  task automatic idle_in();
    rst = 0; en = 1; start = 0; stop = 0; load = 0;
  endtask

  initial begin
    rst = 1; en = 0; start = 0; stop = 0; loop = 0;
    load = 0; load_val = '0;
    #2;
    tick(0, 0, 0, "reset0");
    tick(0, 0, 0, "reset1");

    // Loop mode: two full periods of 31 edges.
    idle_in(); loop = 1; start = 1;
    tick(30, 0, 1, "lp_start");
    start = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 29; k >= 0; k--)
        tick(6'(k), k == 0, 1, "lp_run");
      tick(30, 0, 1, "lp_wrap");
    end

    // Reset mid-run at count 17.
    for (int k = 29; k >= 17; k--)
      tick(6'(k), 0, 1, "pre_rst");
    rst = 1;
    tick(0, 0, 0, "rst_mid0");
    tick(0, 0, 0, "rst_mid1");
    rst = 0;

    // One-shot.
    loop = 0; start = 1;
    tick(30, 0, 1, "os_start");
    start = 0;
    for (int k = 29; k >= 1; k--)
      tick(6'(k), 0, 1, "os_run");
    tick(0, 1, 0, "os_tc");
    for (int k = 0; k < 3; k++)
      tick(0, 0, 0, "os_after");

    // Stop at 12, hold, restart.
    loop = 1; start = 1;
    tick(30, 0, 1, "sp_start");
    start = 0;
    for (int k = 29; k >= 12; k--)
      tick(6'(k), 0, 1, "sp_run");
    stop = 1;
    tick(12, 0, 0, "sp_stop");
    stop = 0;
    tick(12, 0, 0, "sp_hold0");
    tick(12, 0, 0, "sp_hold1");
    start = 1;
    tick(30, 0, 1, "sp_restart");

    // Load wins over start, state unchanged.
    load = 1; load_val = 6'd5;
    tick(5, 0, 1, "ld_start");
    load = 0; start = 0;
    tick(4, 0, 1, "ld_dec");

    // en=0 holds in RUN.
    en = 0;
    tick(4, 0, 1, "en_hold0");
    tick(4, 0, 1, "en_hold1");
    en = 1;

    // Stop in IDLE, load in IDLE keeps IDLE.
    stop = 1;
    tick(4, 0, 0, "ld_stop");
    stop = 0; load = 1; load_val = 6'd9;
    tick(9, 0, 0, "ld_idle");
    load = 0;
    tick(9, 0, 0, "ld_idle_hold");

    // Over-range load in RUN, then loop down and wrap.
    start = 1;
    tick(30, 0, 1, "cl_start");
    start = 0; load = 1; load_val = 6'd50;
    tick(CL, 0, 1, "cl_load");
    load = 0;
    for (int k = int'(CL) - 1; k >= 0; k--)
      tick(6'(k), k == 0, 1, "cl_run");
    tick(30, 0, 1, "cl_wrap");

    // Load 0 in RUN then one-shot: goes IDLE, no tc.
    load = 1; load_val = 6'd0;
    tick(0, 0, 1, "z_load");
    load = 0; loop = 0;
    tick(0, 0, 0, "z_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
